// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell walks a WIDTH-bit
// operand pair LSB first and reports sum, carry-out and signed overflow.
module serial_add_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s, fa_co;
   logic [WIDTH-1:0] sum_shift;

   assign fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign fa_co = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

   // New sum bit enters at the MSB; the widened shift also covers WIDTH=1.
   assign sum_shift = WIDTH'({fa_s, sum_sh_q} >> 1);

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      co_d     = co_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               carry_d  = ci;
               cnt_d    = '0;
               sum_sh_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            sum_sh_d = sum_shift;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_co;
            cnt_d    = cnt_q + CNT_W'(1);
            // carry_q here is the carry into the MSB, giving signed overflow.
            if (cnt_q == LAST) begin
               s_d     = sum_shift;
               co_d    = fa_co;
               ovf_d   = carry_q ^ fa_co;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         s_q      <= '0;
         co_q     <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         s_q      <= s_d;
         co_q     <= co_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=1, 8 and 16, checked against
// plain-arithmetic addition and a sign-based overflow rule.
module tb_serial_add_ctrl;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   logic        start1, ci1, s1, co1, ovf1, busy1, done1;
   logic [0:0]  a1, b1;
   logic        start8, ci8, co8, ovf8, busy8, done8;
   logic [7:0]  a8, b8, s8;
   logic        start16, ci16, co16, ovf16, busy16, done16;
   logic [15:0] a16, b16, s16;

   exp_t exp1[$];
   exp_t exp8[$];
   exp_t exp16[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
      .s(s1), .co(co1), .ovf(ovf1), .busy(busy1), .done(done1));

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
      .s(s8), .co(co8), .ovf(ovf8), .busy(busy8), .done(done8));

   serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .ci(ci16),
      .s(s16), .co(co16), .ovf(ovf16), .busy(busy16), .done(done16));

   // Reference: integer addition, overflow when like-signed operands give an unlike-signed sum.
   function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic cv);
      logic [31:0] mask;
      logic [32:0] full;
      exp_t        e;
      mask  = (32'd1 << w) - 32'd1;
      av    = av & mask;
      bv    = bv & mask;
      full  = {1'b0, av} + {1'b0, bv} + 33'(cv);
      e.s   = full[31:0] & mask;
      e.co  = full[w];
      e.ovf = (av[w-1] == bv[w-1]) && (e.s[w-1] != av[w-1]);
      return e;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else
         n_pass++;
   endtask

   task automatic flag_error(input string name);
      n_chk++;
      $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cyc);
   endtask

   task automatic push_exp(input int w, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv);
      case (w)
         1:       exp1.push_back(model(1, av, bv, cv));
         8:       exp8.push_back(model(8, av, bv, cv));
         default: exp16.push_back(model(16, av, bv, cv));
      endcase
   endtask

   task automatic compare_result(input string tag, input exp_t e, input logic [31:0] act_s,
                                 input logic act_co, input logic act_ovf, input logic act_busy);
      check_output({tag, "_s"}, act_s, e.s);
      check_output({tag, "_co"}, 32'(act_co), 32'(e.co));
      check_output({tag, "_ovf"}, 32'(act_ovf), 32'(e.ovf));
      check_output({tag, "_busy_at_done"}, 32'(act_busy), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && done1) begin
         if (exp1.size() == 0) flag_error("w1_unexpected_done");
         else compare_result("w1", exp1.pop_front(), 32'(s1), co1, ovf1, busy1);
      end
      if (rst_n && done8) begin
         if (exp8.size() == 0) flag_error("w8_unexpected_done");
         else compare_result("w8", exp8.pop_front(), 32'(s8), co8, ovf8, busy8);
      end
      if (rst_n && done16) begin
         if (exp16.size() == 0) flag_error("w16_unexpected_done");
         else compare_result("w16", exp16.pop_front(), 32'(s16), co16, ovf16, busy16);
      end
   end

   task automatic apply_stimulus(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input bit push);
      case (w)
         1:       begin start1 = 1'b1; a1 = av[0]; b1 = bv[0]; ci1 = cv; end
         8:       begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; ci8 = cv; end
         default: begin start16 = 1'b1; a16 = av[15:0]; b16 = bv[15:0]; ci16 = cv; end
      endcase
      @(posedge clk);
      #1;
      case (w)
         1:       start1 = 1'b0;
         8:       start8 = 1'b0;
         default: start16 = 1'b0;
      endcase
      if (push) push_exp(w, av, bv, cv);
   endtask

   // Returns the number of falling edges from the accepting edge to done.
   task automatic wait_done(input int w, output int n);
      logic got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 4 * w + 20) begin
         @(negedge clk);
         n++;
         got = (w == 1) ? done1 : (w == 8) ? done8 : done16;
      end
      if (!got) begin
         n_chk++;
         $display("[TB] FAIL w%0d_done_timeout: got no done, expected done within %0d cycles",
                  w, n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv);
      int lat;
      apply_stimulus(w, av, bv, cv, 1'b1);
      wait_done(w, lat);
      check_output($sformatf("w%0d_latency", w), lat, w + 1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish by 1ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          t_prev, n;
      logic [31:0] t_now;
      start1 = 0; a1 = 0; b1 = 0; ci1 = 0;
      start8 = 0; a8 = 0; b8 = 0; ci8 = 0;
      start16 = 0; a16 = 0; b16 = 0; ci16 = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_output("rst_s8", 32'(s8), 0);
      check_output("rst_co8", 32'(co8), 0);
      check_output("rst_ovf8", 32'(ovf8), 0);
      check_output("rst_busy8", 32'(busy8), 0);
      check_output("rst_done8", 32'(done8), 0);
      check_output("rst_s16", 32'(s16), 0);
      check_output("rst_busy1", 32'(busy1), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++)
         run_op(1, 32'(i[1]), 32'(i[0]), i[2]);

      run_op(8, 32'hFF, 32'h01, 1'b0);
      run_op(8, 32'h7F, 32'h01, 1'b0);

      // Busy/done timing while s holds the previous result (8'h80).
      apply_stimulus(8, 32'hA5, 32'h5A, 1'b1, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check_output($sformatf("timing_busy_c%0d", k), 32'(busy8), 32'(k <= 8));
         check_output($sformatf("timing_done_c%0d", k), 32'(done8), 32'(k == 9));
         if (k <= 8) check_output($sformatf("timing_s_hold_c%0d", k), 32'(s8), 32'h80);
      end
      @(posedge clk);
      #1;

      // Starts and operand changes during RUN must be ignored.
      apply_stimulus(8, 32'h11, 32'h22, 1'b0, 1'b1);
      @(posedge clk);
      #1 a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 start8 = 1'b1; a8 = 8'h99;
      @(posedge clk);
      #1 start8 = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check_output($sformatf("ignore_busy_c%0d", k), 32'(busy8), 0);
         check_output($sformatf("ignore_done_c%0d", k), 32'(done8), 32'(k == 1));
      end
      @(posedge clk);
      #1;

      // Start held high: three back-to-back operations, dones 10 cycles apart.
      for (int i = 0; i < 3; i++) push_exp(8, 32'h12, 32'h34, 1'b1);
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
      t_prev = 0;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!done8 && n < 40);
         if (!done8) begin
            n_chk++;
            $display("[TB] FAIL hold_done_timeout: got no done, expected done #%0d", i);
         end
         t_now = 32'(cyc);
         if (i > 0) check_output($sformatf("hold_spacing_%0d", i), t_now - 32'(t_prev), 32'd10);
         t_prev = int'(t_now);
         if (i == 2) start8 = 1'b0;
      end
      @(posedge clk);
      #1;

      // Leave co/ovf/s nonzero, then abort an operation with reset.
      run_op(8, 32'h80, 32'h81, 1'b0);
      apply_stimulus(8, 32'h80, 32'h80, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("abort_s8", 32'(s8), 0);
      check_output("abort_co8", 32'(co8), 0);
      check_output("abort_ovf8", 32'(ovf8), 0);
      check_output("abort_busy8", 32'(busy8), 0);
      check_output("abort_done8", 32'(done8), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check_output($sformatf("abort_no_done_c%0d", k), 32'(done8), 0);
      end
      @(posedge clk);
      #1;
      run_op(8, 32'h80, 32'h80, 1'b0);

      fork
         for (int i = 0; i < 1000; i++) run_op(8, $urandom, $urandom, 1'($urandom));
         for (int i = 0; i < 1000; i++) run_op(16, $urandom, $urandom, 1'($urandom));
      join

      repeat (4) @(negedge clk);
      check_output("w1_queue_empty", exp1.size(), 0);
      check_output("w8_queue_empty", exp8.size(), 0);
      check_output("w16_queue_empty", exp16.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single 1-bit full-adder cell over a WIDTH-bit operand pair, LSB first, one bit per clock. Operands are captured on a start handshake, and the block reports sum, carry-out and signed overflow with a one-cycle done pulse. This lets a multi-bit add share one full-adder resource instead of a WIDTH-wide ripple chain.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH)+1, bit counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
ci  input  1  carry-in; captured on accepted start
s  output  WIDTH  registered sum; valid from done, held until next completion
co  output  1  registered carry-out; same timing as s
ovf  output  1  registered signed overflow = carry into MSB XOR carry out of MSB
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), all flops cleared on assertion regardless of clk.
- Reset values: s=0, co=0, ovf=0, busy=0, done=0, state=IDLE, operand/shift/carry/counter registers=0.
- States are IDLE, RUN and DONE; 2-bit encoding.
- IDLE: when start=1 at a clock edge:
  - load a_sh<=a, b_sh<=b, carry<=ci, cnt<=0, sum_sh<=0.
  - go to RUN.
  - Otherwise stay in IDLE.
- RUN: each cycle, the FA cell computes from a_sh[0], b_sh[0] and carry. On the edge:
  - sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}.
  - a_sh, b_sh shift right by 1 with zero fill.
  - carry <= fa_co.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, additionally:
    - s <= {fa_s, sum_sh[WIDTH-1:1]}.
    - co <= fa_co.
    - ovf <= carry XOR fa_co, using the carry into the MSB.
    - go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency: start sampled at edge E0 -> busy high for cycles E0..E0+WIDTH-1 -> done high during the cycle after edge E0+WIDTH. Result is visible on s/co/ovf in that same cycle. Throughput is one add per WIDTH+2 cycles.
- start in RUN or DONE is ignored: no queueing, no abort. A start held high continuously is re-accepted in the first IDLE cycle after DONE.
- a, b, ci changing during RUN have no effect; only captured copies are used.
- s/co/ovf change only on the completing edge; during RUN they hold the previous result.
- WIDTH=1: RUN lasts one cycle; s equals the full-adder truth table output for {ci,a,b}.
- rst_n asserted mid-RUN: the operation is discarded, all outputs return to reset values, and no done is issued. After deassertion the block is in IDLE.
- done and busy are never high together. busy, done and the outputs are driven directly from flops, with no combinational path from inputs.
- The full-adder cell is purely combinational: s = a^b^ci, co = ab | ci(a^b).

Test Plan:
- WIDTH=1, all 8 {ci,a,b} combos 000..111 -> (s,co) = 00,10,10,01,10,01,01,11 in that order; done 2 cycles after each start.
- WIDTH=8: a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1, ovf=0. a=8'h7F, b=8'h01, ci=0 -> s=8'h80, co=0, ovf=1.
- WIDTH=8: a=8'hA5, b=8'h5A, ci=1 -> s=8'h00, co=1, ovf=0. Check busy high exactly 8 cycles and done exactly one cycle, on cycle 9 after the start edge.
- Pulse start again at cycles 3 and 8 of a run with different operands, and change a/b mid-run -> first result unaffected and no second done. Then hold start high -> back-to-back ops, each done spaced by 10 cycles.
- Assert rst_n low at RUN cycle 4 of a=8'h80, b=8'h80 -> outputs 0 immediately and asynchronously, no done. Next op a=8'h80, b=8'h80, ci=0 -> s=8'h00, co=1, ovf=1.
- Random 1000 ops at WIDTH=8 and WIDTH=16 -> {co,s} == a+b+ci and ovf matches the signed-overflow reference model every done.
